mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM between instruction fetch (IF port) and the
//  MEM-stage load/store path (DM port), replacing separate instr_ram/data_ram instances.

---
 rtl/mem_port_arbiter.sv | 80 ++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Data wins by default; a counter bounds how long a waiting fetch can be starved.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_mode,
  input  logic        dm_us,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [2:0]  sram_mode,
  output logic        sram_us,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnDm} owner_e;

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  owner_e           resp_owner_q;
  logic             starve_hit;

  always_comb begin
    starve_hit = if_req && (starve_cnt_q == Limit);
    if_gnt     = !reset && if_req && (!dm_req || starve_hit);
    dm_gnt     = !reset && dm_req && !starve_hit;

    sram_en    = if_gnt || dm_gnt;
    sram_we    = dm_gnt && dm_we;
    sram_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : 32'h0);
    sram_wdata = dm_gnt ? dm_wdata : 32'h0;
    sram_mode  = dm_gnt ? dm_mode : 3'b010;
    sram_us    = dm_gnt ? dm_us : 1'b0;

    // Responses still in flight while reset is asserted are dropped.
    if_rvalid  = !reset && (resp_owner_q == OwnIf);
    dm_rvalid  = !reset && (resp_owner_q == OwnDm);
    if_rdata   = if_rvalid ? sram_rdata : 32'h0;
    dm_rdata   = dm_rvalid ? sram_rdata : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      resp_owner_q <= OwnNone;
    end else begin
      if (dm_gnt && if_req) begin
        if (starve_cnt_q != Limit) starve_cnt_q <= starve_cnt_q + 1'b1;
      end else if (if_gnt || !if_req) begin
        starve_cnt_q <= '0;
      end

      if (if_gnt) begin
        resp_owner_q <= OwnIf;
      end else if (dm_gnt && !dm_we) begin
        resp_owner_q <= OwnDm;
      end else begin
        resp_owner_q <= OwnNone;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural SRAM model on the shared port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [2:0]  dm_mode;
  logic        dm_us;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        sram_en, sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [2:0]  sram_mode;
  logic        sram_us;
  logic [31:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_mode    (dm_mode),
    .dm_us      (dm_us),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_mode  (sram_mode),
    .sram_us    (sram_us),
    .sram_rdata (sram_rdata)
  );

  // SRAM model: unwritten word at index k reads as 0xA000_0000 + k.
  logic [31:0] mem      [256];
  logic        wr_valid [256];
  logic [7:0]  idx;
  assign idx = sram_addr[9:2];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
    end else if (sram_en) begin
      if (sram_we) begin
        mem[idx]      <= sram_wdata;
        wr_valid[idx] <= 1'b1;
      end else begin
        sram_rdata <= wr_valid[idx] ? mem[idx] : (32'hA000_0000 | {24'h0, idx});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_dm;
    reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h0000_0040; dm_addr = 32'h0000_0200; dm_wdata = 32'h0;
    dm_mode = 3'b010; dm_us = 1'b0; sram_rdata = 32'h0;
    tick(); tick();

    // Reset holds off everything even with both requests up
    @(negedge clk);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    tick();
    reset = 1'b0;

    // Both held for 10 cycles: DDDDI DDDDI
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_dm = (i % 5) != 4;
      chk("starve_dm_gnt", dm_gnt, exp_dm);
      chk("starve_if_gnt", if_gnt, !exp_dm);
      if (i == 0) chk("post_rst_dm_rvalid", dm_rvalid, 0);
      if (i == 1) chk("load_dm_rvalid", dm_rvalid, 1);
      if (i == 4) chk("starve_sram_addr", sram_addr, 32'h0000_0040);
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Consecutive fetches
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    chk("if0_gnt", if_gnt, 1);
    chk("if0_sram_addr", sram_addr, 32'h0);
    chk("if0_sram_en", sram_en, 1);
    tick();
    if_addr = 32'h4;
    @(negedge clk);
    chk("if1_gnt", if_gnt, 1);
    chk("if1_rvalid", if_rvalid, 1);
    chk("if1_rdata", if_rdata, 32'hA000_0000);
    chk("if1_dm_rvalid", dm_rvalid, 0);
    chk("if1_dm_rdata", dm_rdata, 32'h0);
    tick();
    if_addr = 32'h8;
    @(negedge clk);
    chk("if2_rdata", if_rdata, 32'hA000_0001);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("if3_rvalid", if_rvalid, 1);
    chk("if3_rdata", if_rdata, 32'hA000_0002);
    chk("if3_gnt", if_gnt, 0);
    chk("if3_sram_en", sram_en, 0);
    tick();
    @(negedge clk);
    chk("if4_rvalid", if_rvalid, 0);
    tick();

    // Store then load to the same address
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    dm_mode = 3'b000; dm_us = 1'b1;
    @(negedge clk);
    chk("st_gnt", dm_gnt, 1);
    chk("st_sram_we", sram_we, 1);
    chk("st_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    chk("st_sram_mode", sram_mode, 3'b000);
    chk("st_sram_us", sram_us, 1);
    chk("st_sram_addr", sram_addr, 32'h100);
    tick();
    dm_we = 1'b0;
    @(negedge clk);
    chk("st_no_rvalid", dm_rvalid, 0);
    chk("ld_gnt", dm_gnt, 1);
    chk("ld_sram_we", sram_we, 0);
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    chk("ld_rvalid", dm_rvalid, 1);
    chk("ld_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("idle_sram_mode", sram_mode, 3'b010);
    chk("idle_sram_wdata", sram_wdata, 32'h0);
    chk("idle_sram_us", sram_us, 0);
    tick();

    // IF grant at N, DM load at N+1: responses stay with their owners
    dm_mode = 3'b010; dm_us = 1'b0;
    if_req = 1'b1; if_addr = 32'h0C;
    @(negedge clk);
    chk("mix_if_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h10;
    @(negedge clk);
    chk("mix_dm_gnt", dm_gnt, 1);
    chk("mix_if_rvalid", if_rvalid, 1);
    chk("mix_if_rdata", if_rdata, 32'hA000_0003);
    chk("mix_dm_rvalid0", dm_rvalid, 0);
    chk("mix_dm_rdata0", dm_rdata, 32'h0);
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    chk("mix_dm_rvalid1", dm_rvalid, 1);
    chk("mix_dm_rdata1", dm_rdata, 32'hA000_0004);
    chk("mix_if_rvalid1", if_rvalid, 0);
    chk("mix_if_rdata1", if_rdata, 32'h0);
    tick();

    // Load granted, then reset: response dropped and starvation count cleared
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h14; if_addr = 32'h18;
    tick();
    @(negedge clk);
    chk("rr_dm_gnt", dm_gnt, 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rr_dm_rvalid", dm_rvalid, 0);
    chk("rr_dm_rdata", dm_rdata, 32'h0);
    chk("rr_dm_gnt_rst", dm_gnt, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("rr_post_rvalid", dm_rvalid, 0);
      exp_dm = (i != 4);
      chk("rr_cnt_dm_gnt", dm_gnt, exp_dm);
      chk("rr_cnt_if_gnt", if_gnt, !exp_dm);
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
